decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 136 +++++++++++++
 tb/tb_decode_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// MIPS-subset decode stage: 32-entry register file with write-back bypass,
// instruction decode to ALU operands/op, and a one-deep valid/stall output register.
module decode_stage #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
) (
  input  logic              d_clk,
  input  logic              d_rst_n,
  input  logic [31:0]       d_i_instr,
  input  logic              d_i_valid,
  output logic              d_o_ready,
  input  logic              d_i_stall,
  input  logic              d_i_flush,
  input  logic              d_i_wb_en,
  input  logic [AWIDTH-1:0] d_i_wb_addr,
  input  logic [DWIDTH-1:0] d_i_wb_data,
  output logic [DWIDTH-1:0] d_o_data_rs,
  output logic [DWIDTH-1:0] d_o_data_rt,
  output logic [3:0]        d_o_funct,
  output logic [AWIDTH-1:0] d_o_rd_addr,
  output logic              d_o_reg_write,
  output logic              d_o_valid,
  output logic              d_o_illegal,
  output logic [15:0]       d_o_issue_cnt
);
  localparam int NREG = 2**AWIDTH;

  logic [DWIDTH-1:0] rf_q [NREG];
  logic [AWIDTH-1:0] rs_a, rt_a, rd_a, dec_dest;
  logic [DWIDTH-1:0] rs_v, rt_v, dec_rt_v, imm_s, imm_z;
  logic [5:0]        opc, fn;
  logic [3:0]        dec_funct;
  logic              dec_legal, capture;
  logic              unused_shamt;

  logic [DWIDTH-1:0] rs_d, rs_q, rt_d, rt_q;
  logic [3:0]        funct_d, funct_q;
  logic [AWIDTH-1:0] rd_d, rd_q;
  logic              rw_d, rw_q, vld_d, vld_q, ill_d, ill_q;
  logic [15:0]       cnt_d, cnt_q;

  assign opc   = d_i_instr[31:26];
  assign fn    = d_i_instr[5:0];
  assign rs_a  = d_i_instr[21 +: AWIDTH];
  assign rt_a  = d_i_instr[16 +: AWIDTH];
  assign rd_a  = d_i_instr[11 +: AWIDTH];
  assign imm_s = {{(DWIDTH-16){d_i_instr[15]}}, d_i_instr[15:0]};
  assign imm_z = {{(DWIDTH-16){1'b0}}, d_i_instr[15:0]};
  assign unused_shamt = ^d_i_instr[10:6];

  always_ff @(posedge d_clk or negedge d_rst_n) begin
    if (!d_rst_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (d_i_wb_en && d_i_wb_addr != '0) begin
      rf_q[d_i_wb_addr] <= d_i_wb_data;
    end
  end

  // Same-cycle write-back is forwarded so an instruction never sees a stale value.
  always_comb begin
    rs_v = rf_q[rs_a];
    if (rs_a == '0) rs_v = '0;
    else if (d_i_wb_en && d_i_wb_addr == rs_a) rs_v = d_i_wb_data;
    rt_v = rf_q[rt_a];
    if (rt_a == '0) rt_v = '0;
    else if (d_i_wb_en && d_i_wb_addr == rt_a) rt_v = d_i_wb_data;
  end

  always_comb begin
    dec_legal = 1'b0;
    dec_funct = 4'd0;
    dec_rt_v  = rt_v;
    dec_dest  = rd_a;
    case (opc)
      6'h00: case (fn)
        6'h20: begin dec_legal = 1'b1; dec_funct = 4'd0; end
        6'h22: begin dec_legal = 1'b1; dec_funct = 4'd1; end
        6'h24: begin dec_legal = 1'b1; dec_funct = 4'd2; end
        6'h25: begin dec_legal = 1'b1; dec_funct = 4'd3; end
        6'h2A: begin dec_legal = 1'b1; dec_funct = 4'd4; end
        default: ;
      endcase
      6'h08: begin dec_legal = 1'b1; dec_funct = 4'd0; dec_rt_v = imm_s; dec_dest = rt_a; end
      6'h0A: begin dec_legal = 1'b1; dec_funct = 4'd4; dec_rt_v = imm_s; dec_dest = rt_a; end
      6'h0C: begin dec_legal = 1'b1; dec_funct = 4'd2; dec_rt_v = imm_z; dec_dest = rt_a; end
      6'h0D: begin dec_legal = 1'b1; dec_funct = 4'd3; dec_rt_v = imm_z; dec_dest = rt_a; end
      default: ;
    endcase
  end

  assign d_o_ready = !vld_q || !d_i_stall;
  assign capture   = d_i_valid && d_o_ready;

  // Flush wins over both capture and stall hold, and suppresses the issue count.
  always_comb begin
    rs_d = rs_q; rt_d = rt_q; funct_d = funct_q; rd_d = rd_q;
    rw_d = rw_q; vld_d = vld_q; ill_d = ill_q; cnt_d = cnt_q;
    if (capture) begin
      rs_d    = rs_v;
      rt_d    = dec_rt_v;
      funct_d = dec_funct;
      rd_d    = dec_dest;
      rw_d    = dec_legal && (dec_dest != '0);
      ill_d   = !dec_legal;
      vld_d   = 1'b1;
      cnt_d   = cnt_q + 16'd1;
    end else if (d_o_ready) begin
      vld_d = 1'b0;
    end
    if (d_i_flush) begin
      vld_d = 1'b0;
      rw_d  = 1'b0;
      ill_d = 1'b0;
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge d_clk or negedge d_rst_n) begin
    if (!d_rst_n) begin
      rs_q <= '0; rt_q <= '0; funct_q <= '0; rd_q <= '0;
      rw_q <= 1'b0; vld_q <= 1'b0; ill_q <= 1'b0; cnt_q <= '0;
    end else begin
      rs_q <= rs_d; rt_q <= rt_d; funct_q <= funct_d; rd_q <= rd_d;
      rw_q <= rw_d; vld_q <= vld_d; ill_q <= ill_d; cnt_q <= cnt_d;
    end
  end

  assign d_o_data_rs   = rs_q;
  assign d_o_data_rt   = rt_q;
  assign d_o_funct     = funct_q;
  assign d_o_rd_addr   = rd_q;
  assign d_o_reg_write = rw_q;
  assign d_o_valid     = vld_q;
  assign d_o_illegal   = ill_q;
  assign d_o_issue_cnt = cnt_q;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus randomized traffic checked
// against an instruction-level reference model.
module tb_decode_stage;
  logic        d_clk = 0, d_rst_n = 0;
  logic [31:0] d_i_instr = 0;
  logic        d_i_valid = 0, d_i_stall = 0, d_i_flush = 0, d_i_wb_en = 0;
  logic [4:0]  d_i_wb_addr = 0;
  logic [31:0] d_i_wb_data = 0;
  logic        d_o_ready, d_o_reg_write, d_o_valid, d_o_illegal;
  logic [31:0] d_o_data_rs, d_o_data_rt;
  logic [3:0]  d_o_funct;
  logic [4:0]  d_o_rd_addr;
  logic [15:0] d_o_issue_cnt;

  int errors = 0, checks = 0;

  decode_stage #(.DWIDTH(32), .AWIDTH(5)) dut (
    .d_clk(d_clk), .d_rst_n(d_rst_n), .d_i_instr(d_i_instr), .d_i_valid(d_i_valid),
    .d_o_ready(d_o_ready), .d_i_stall(d_i_stall), .d_i_flush(d_i_flush),
    .d_i_wb_en(d_i_wb_en), .d_i_wb_addr(d_i_wb_addr), .d_i_wb_data(d_i_wb_data),
    .d_o_data_rs(d_o_data_rs), .d_o_data_rt(d_o_data_rt), .d_o_funct(d_o_funct),
    .d_o_rd_addr(d_o_rd_addr), .d_o_reg_write(d_o_reg_write), .d_o_valid(d_o_valid),
    .d_o_illegal(d_o_illegal), .d_o_issue_cnt(d_o_issue_cnt));

  always #5 d_clk = ~d_clk;

  // Reference model: architectural register contents and the last issued instruction.
  logic [31:0] m_regs [32];
  logic        m_valid, m_rw, m_ill, m_flushed;
  logic [31:0] m_rs, m_rt;
  logic [3:0]  m_fn;
  logic [4:0]  m_rd;
  logic [15:0] m_cnt;
  logic [5:0]  rfun [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  logic [5:0]  iop  [4] = '{6'h08, 6'h0A, 6'h0C, 6'h0D};
  logic [3:0]  ifn  [4] = '{4'd0, 4'd4, 4'd2, 4'd3};

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
    m_valid = 0; m_rw = 0; m_ill = 0; m_flushed = 0;
    m_rs = 0; m_rt = 0; m_fn = 0; m_rd = 0; m_cnt = 0;
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 0) return 0;
    if (d_i_wb_en && d_i_wb_addr == a) return d_i_wb_data;
    return m_regs[a];
  endfunction

  task automatic mdec(input logic [31:0] ins, output logic lg, output logic [3:0] fn,
                      output logic [31:0] a, output logic [31:0] b, output logic [4:0] ds);
    lg = 0; fn = 0; a = mread(ins[25:21]); b = mread(ins[20:16]); ds = ins[15:11];
    if (ins[31:26] == 0) begin
      for (int k = 0; k < 5; k++) if (ins[5:0] == rfun[k]) begin lg = 1; fn = 4'(k); end
    end else begin
      for (int k = 0; k < 4; k++) if (ins[31:26] == iop[k]) begin
        lg = 1; fn = ifn[k]; ds = ins[20:16];
        b = (k < 2) ? 32'($signed(ins[15:0])) : {16'h0, ins[15:0]};
      end
    end
  endtask

  // Advance one clock: update model from the inputs presented now, then move to the next negedge.
  task automatic cycle();
    logic rdy, lg; logic [3:0] fn; logic [31:0] a, b; logic [4:0] ds;
    rdy = !m_valid || !d_i_stall;
    mdec(d_i_instr, lg, fn, a, b, ds);
    m_flushed = d_i_flush;
    if (d_i_flush) begin m_valid = 0; m_rw = 0; m_ill = 0; end
    else if (d_i_valid && rdy) begin
      m_valid = 1; m_rs = a; m_rt = b; m_fn = fn; m_rd = ds;
      m_ill = !lg; m_rw = lg && (ds != 0); m_cnt = m_cnt + 16'd1;
    end else if (rdy) m_valid = 0;
    if (d_i_wb_en && d_i_wb_addr != 0) m_regs[d_i_wb_addr] = d_i_wb_data;
    @(posedge d_clk); @(negedge d_clk);
  endtask

  task automatic idle_inputs();
    d_i_valid = 0; d_i_stall = 0; d_i_flush = 0; d_i_wb_en = 0; d_i_instr = 0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (d_o_valid !== 0) begin errors++; $display("FAIL rst_valid got %0d want 0", d_o_valid); end
    checks++; if (d_o_ready !== 1) begin errors++; $display("FAIL rst_ready got %0d want 1", d_o_ready); end
    checks++; if ({d_o_data_rs, d_o_data_rt, d_o_funct, d_o_rd_addr, d_o_reg_write, d_o_illegal} !== 0)
      begin errors++; $display("FAIL rst_outputs got rs=%h rt=%h fn=%0d rd=%0d want all 0", d_o_data_rs, d_o_data_rt, d_o_funct, d_o_rd_addr); end
    checks++; if (d_o_issue_cnt !== 0) begin errors++; $display("FAIL rst_cnt got %0d want 0", d_o_issue_cnt); end
    model_reset();
    @(negedge d_clk); @(negedge d_clk);
    d_rst_n = 1;
  endtask

  task automatic test_rtype();
    d_i_wb_en = 1; d_i_wb_addr = 1; d_i_wb_data = 5; cycle();
    d_i_wb_addr = 2; d_i_wb_data = 4; cycle();
    d_i_wb_en = 0; d_i_valid = 1; d_i_instr = 32'h00221820; cycle();
    d_i_valid = 0;
    checks++; if (d_o_data_rs !== 32'd5) begin errors++; $display("FAIL rtype_rs got %h want 5", d_o_data_rs); end
    checks++; if (d_o_data_rt !== 32'd4) begin errors++; $display("FAIL rtype_rt got %h want 4", d_o_data_rt); end
    checks++; if (d_o_funct !== 4'd0 || d_o_rd_addr !== 5'd3) begin errors++; $display("FAIL rtype_fn_rd got %0d/%0d want 0/3", d_o_funct, d_o_rd_addr); end
    checks++; if (d_o_reg_write !== 1 || d_o_valid !== 1) begin errors++; $display("FAIL rtype_rw_valid got %0d/%0d want 1/1", d_o_reg_write, d_o_valid); end
    checks++; if (d_o_issue_cnt !== 16'd1) begin errors++; $display("FAIL rtype_cnt got %0d want 1", d_o_issue_cnt); end
  endtask

  task automatic test_bypass();
    d_i_wb_en = 1; d_i_wb_addr = 1; d_i_wb_data = 7;
    d_i_valid = 1; d_i_instr = 32'h00221822; cycle();
    d_i_wb_en = 0; d_i_valid = 0;
    checks++; if (d_o_data_rs !== 32'd7) begin errors++; $display("FAIL bypass_rs got %h want 7", d_o_data_rs); end
    checks++; if (d_o_funct !== 4'd1) begin errors++; $display("FAIL bypass_fn got %0d want 1", d_o_funct); end
  endtask

  task automatic test_immediate();
    d_i_valid = 1; d_i_instr = 32'h2004FFFF; cycle();
    checks++; if (d_o_data_rs !== 0 || d_o_data_rt !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_ops got %h/%h want 0/ffffffff", d_o_data_rs, d_o_data_rt); end
    checks++; if (d_o_funct !== 4'd0 || d_o_rd_addr !== 5'd4) begin errors++; $display("FAIL addi_fn_rd got %0d/%0d want 0/4", d_o_funct, d_o_rd_addr); end
    d_i_instr = 32'h3404FFFF; cycle();
    d_i_valid = 0;
    checks++; if (d_o_data_rt !== 32'h0000FFFF || d_o_funct !== 4'd3) begin errors++; $display("FAIL ori got rt=%h fn=%0d want 0000ffff/3", d_o_data_rt, d_o_funct); end
  endtask

  task automatic test_stall();
    d_i_stall = 1; d_i_valid = 1; d_i_instr = 32'h00221820;
    #1;
    checks++; if (d_o_ready !== 0) begin errors++; $display("FAIL stall_ready got %0d want 0", d_o_ready); end
    cycle();
    checks++; if (d_o_data_rt !== 32'h0000FFFF || d_o_funct !== 4'd3 || d_o_valid !== 1) begin errors++; $display("FAIL stall_hold got rt=%h fn=%0d v=%0d want 0000ffff/3/1", d_o_data_rt, d_o_funct, d_o_valid); end
    checks++; if (d_o_issue_cnt !== 16'd4) begin errors++; $display("FAIL stall_cnt got %0d want 4", d_o_issue_cnt); end
    d_i_stall = 0; cycle();
    d_i_valid = 0;
    checks++; if (d_o_data_rs !== 32'd7 || d_o_data_rt !== 32'd4 || d_o_rd_addr !== 5'd3) begin errors++; $display("FAIL unstall_issue got %h/%h/%0d want 7/4/3", d_o_data_rs, d_o_data_rt, d_o_rd_addr); end
    checks++; if (d_o_issue_cnt !== 16'd5) begin errors++; $display("FAIL unstall_cnt got %0d want 5", d_o_issue_cnt); end
  endtask

  task automatic test_illegal_flush();
    d_i_valid = 1; d_i_instr = 32'h8C000000; cycle();
    checks++; if (d_o_illegal !== 1 || d_o_reg_write !== 0 || d_o_funct !== 0 || d_o_valid !== 1) begin errors++; $display("FAIL illegal got ill=%0d rw=%0d fn=%0d v=%0d want 1/0/0/1", d_o_illegal, d_o_reg_write, d_o_funct, d_o_valid); end
    d_i_flush = 1; d_i_instr = 32'h00221820; cycle();
    idle_inputs();
    checks++; if (d_o_valid !== 0 || d_o_reg_write !== 0 || d_o_illegal !== 0) begin errors++; $display("FAIL flush got v=%0d rw=%0d ill=%0d want 0/0/0", d_o_valid, d_o_reg_write, d_o_illegal); end
    checks++; if (d_o_issue_cnt !== 16'd6) begin errors++; $display("FAIL flush_cnt got %0d want 6", d_o_issue_cnt); end
  endtask

  task automatic test_random();
    logic [4:0] rs, rt, rd; logic [15:0] imm; logic rdy;
    for (int n = 0; n < 500; n++) begin
      rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
      imm = 16'($urandom);
      case ($urandom_range(0, 3))
        0: d_i_instr = {6'h00, rs, rt, rd, 5'h0, rfun[$urandom_range(0, 4)]};
        1: d_i_instr = {iop[$urandom_range(0, 3)], rs, rt, imm};
        2: d_i_instr = {6'h00, rs, rt, rd, 5'h0, 6'h21};
        default: d_i_instr = {6'h23, rs, rt, imm};
      endcase
      d_i_valid   = ($urandom_range(0, 3) != 0);
      d_i_stall   = ($urandom_range(0, 2) == 0);
      d_i_flush   = ($urandom_range(0, 19) == 0);
      d_i_wb_en   = ($urandom_range(0, 1) == 1);
      d_i_wb_addr = 5'($urandom_range(0, 7));
      d_i_wb_data = $urandom;
      rdy = !m_valid || !d_i_stall;
      #1;
      checks++; if (d_o_ready !== rdy) begin errors++; $display("FAIL rnd_ready n=%0d got %0d want %0d", n, d_o_ready, rdy); end
      cycle();
      checks++; if (d_o_valid !== m_valid || d_o_issue_cnt !== m_cnt) begin errors++; $display("FAIL rnd_valid_cnt n=%0d got %0d/%0d want %0d/%0d", n, d_o_valid, d_o_issue_cnt, m_valid, m_cnt); end
      if (m_flushed) begin
        checks++; if (d_o_reg_write !== 0 || d_o_illegal !== 0) begin errors++; $display("FAIL rnd_flush n=%0d got rw=%0d ill=%0d want 0/0", n, d_o_reg_write, d_o_illegal); end
      end else if (m_valid) begin
        checks++; if (d_o_data_rs !== m_rs || d_o_funct !== m_fn || d_o_illegal !== m_ill || d_o_reg_write !== m_rw)
          begin errors++; $display("FAIL rnd_issue n=%0d got rs=%h fn=%0d ill=%0d rw=%0d want %h/%0d/%0d/%0d", n, d_o_data_rs, d_o_funct, d_o_illegal, d_o_reg_write, m_rs, m_fn, m_ill, m_rw); end
        if (!m_ill) begin
          checks++; if (d_o_data_rt !== m_rt || d_o_rd_addr !== m_rd) begin errors++; $display("FAIL rnd_rt_rd n=%0d got %h/%0d want %h/%0d", n, d_o_data_rt, d_o_rd_addr, m_rt, m_rd); end
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_midstream();
    d_i_valid = 1; d_i_instr = 32'h00221820; cycle();
    #2 d_rst_n = 0;
    #1;
    checks++; if ({d_o_valid, d_o_reg_write, d_o_illegal, d_o_data_rs, d_o_data_rt, d_o_funct, d_o_rd_addr} !== 0)
      begin errors++; $display("FAIL midrst_outputs got v=%0d rs=%h rt=%h want all 0", d_o_valid, d_o_data_rs, d_o_data_rt); end
    checks++; if (d_o_issue_cnt !== 0 || d_o_ready !== 1) begin errors++; $display("FAIL midrst_cnt_ready got %0d/%0d want 0/1", d_o_issue_cnt, d_o_ready); end
    model_reset();
    @(posedge d_clk); @(negedge d_clk);
    d_rst_n = 1;
    for (int i = 1; i < 32; i++) begin
      d_i_instr = {6'h00, 5'(i), 5'(i), 5'(i), 5'h0, 6'h20}; d_i_valid = 1;
      cycle();
      checks++; if (d_o_data_rs !== 0 || d_o_data_rt !== 0 || d_o_issue_cnt !== 16'(i) || d_o_valid !== 1)
        begin errors++; $display("FAIL midrst_read r%0d got rs=%h rt=%h cnt=%0d want 0/0/%0d", i, d_o_data_rs, d_o_data_rt, d_o_issue_cnt, i); end
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    d_rst_n = 0; #1; d_rst_n = 1; model_reset();
    d_i_valid = 1; d_i_instr = 32'h00000020;
    for (int i = 0; i < 65535; i++) begin @(posedge d_clk); @(negedge d_clk); end
    checks++; if (d_o_issue_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_max got %h want ffff", d_o_issue_cnt); end
    @(posedge d_clk); @(negedge d_clk);
    checks++; if (d_o_issue_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h want 0000", d_o_issue_cnt); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_bypass();
    test_immediate();
    test_stall();
    test_illegal_flush();
    test_random();
    test_reset_midstream();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
